// File: rtl/averaging_pkg.sv
// Shared definitions for the averaging chain: interpolator state encoding
// and the accumulator width helper.
package averaging_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } interp_state_e;

    // Accumulator holds sample<<<log2_ratio plus one guard bit for full-scale steps.
    function automatic int acc_width(input int data_bits, input int log2_ratio);
        return data_bits + log2_ratio + 1;
    endfunction

endpackage

// File: rtl/linear_interpolator_if.sv
// Slow-side point stream in, full-rate interpolated stream out.
interface linear_interpolator_if #(
    parameter int DATA_BITS = 16
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 underrun;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_data, out_valid, underrun
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_data, out_valid, underrun
    );
endinterface

// File: rtl/interp_skid.sv
// One-entry input buffer; ready is purely register-driven so the upstream
// valid never reaches in_ready combinationally.
module interp_skid #(
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 consume,
    output logic [DATA_BITS-1:0] nxt,
    output logic                 nxt_valid
);
    logic [DATA_BITS-1:0] nxt_q, nxt_d;
    logic                 nxt_valid_q, nxt_valid_d;

    assign in_ready  = ~nxt_valid_q;
    assign nxt       = nxt_q;
    assign nxt_valid = nxt_valid_q;

    // Fill only when empty and drain only when full, so the two never collide.
    always_comb begin
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        if (consume)
            nxt_valid_d = 1'b0;
        if (in_valid && !nxt_valid_q) begin
            nxt_d       = in_data;
            nxt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nxt_q       <= '0;
            nxt_valid_q <= 1'b0;
        end else begin
            nxt_q       <= nxt_d;
            nxt_valid_q <= nxt_valid_d;
        end
    end

endmodule

// File: rtl/linear_interpolator.sv
// Rate raiser: ramps linearly between consecutive input points over
// 2^LOG2_RATIO output cycles, holding the last point when starved.
module linear_interpolator
    import averaging_pkg::*;
#(
    parameter int DATA_BITS  = 16,
    parameter int LOG2_RATIO = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    linear_interpolator_if.slave  bus
);
    localparam int AW = acc_width(DATA_BITS, LOG2_RATIO);
    localparam int SW = DATA_BITS + 1;

    logic [DATA_BITS-1:0] nxt;
    logic                 nxt_valid;
    logic                 consume;
    logic                 in_ready;

    interp_skid #(.DATA_BITS(DATA_BITS)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_data  (bus.in_data),
        .in_valid (bus.in_valid),
        .in_ready (in_ready),
        .consume  (consume),
        .nxt      (nxt),
        .nxt_valid(nxt_valid)
    );

    interp_state_e               state_q, state_d;
    logic signed [DATA_BITS-1:0] p_tgt_q, p_tgt_d;
    logic signed [SW-1:0]        step_q, step_d;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic [LOG2_RATIO-1:0]       phase_q, phase_d;
    logic                        underrun_q, underrun_d;

    logic signed [SW-1:0] diff;
    logic signed [AW-1:0] nxt_acc;
    logic signed [AW-1:0] step_ext;

    // One extra bit on the difference keeps max-to-min swings from wrapping.
    assign diff     = $signed({nxt[DATA_BITS-1], nxt}) - $signed({p_tgt_q[DATA_BITS-1], p_tgt_q});
    assign nxt_acc  = $signed({nxt[DATA_BITS-1], nxt, {LOG2_RATIO{1'b0}}});
    assign step_ext = $signed({{LOG2_RATIO{step_q[SW-1]}}, step_q});

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = acc_q[LOG2_RATIO +: DATA_BITS];
    assign bus.out_valid = (state_q != IDLE);
    assign bus.underrun  = underrun_q;

    always_comb begin
        state_d    = state_q;
        p_tgt_d    = p_tgt_q;
        step_d     = step_q;
        acc_d      = acc_q;
        phase_d    = phase_q;
        underrun_d = 1'b0;
        consume    = 1'b0;
        case (state_q)
            IDLE: if (nxt_valid) begin
                acc_d   = nxt_acc;
                p_tgt_d = nxt;
                consume = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (nxt_valid) begin
                step_d  = diff;
                p_tgt_d = nxt;
                phase_d = '0;
                consume = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                acc_d   = acc_q + step_ext;
                phase_d = phase_q + 1'b1;
                // Last sample of the segment: acc lands exactly on p_tgt here.
                if (phase_q == '1) begin
                    if (nxt_valid) begin
                        step_d  = diff;
                        p_tgt_d = nxt;
                        phase_d = '0;
                        consume = 1'b1;
                    end else begin
                        state_d    = HOLD;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            p_tgt_q    <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_tgt_q    <= p_tgt_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_linear_interpolator.sv
// Directed bench for linear_interpolator at ratio 4 (LOG2_RATIO=2), 16-bit samples.
module tb_linear_interpolator;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    linear_interpolator_if #(.DATA_BITS(16)) bus ();

    linear_interpolator #(.DATA_BITS(16), .LOG2_RATIO(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    int   seq[4]      = '{0, 40, 0, 40};
    int   tri_out[14] = '{0, 10, 20, 30, 40, 30, 20, 10, 0, 10, 20, 30, 40, 40};
    logic tri_rdy[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   idx;
    logic rdy_prev;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (bounded) for ready, offers one point for one edge, returns on the next negedge.
    task automatic push(input int v);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", bus.in_ready, 1);
        bus.in_data  = 16'(v);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic ramp(input string tag, input int ur_at);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, $signed(bus.out_data), exp_q[i]);
            chk({tag, "_valid"}, bus.out_valid, 1);
            chk({tag, "_ur"}, bus.underrun, (i == ur_at));
            @(negedge clk);
        end
    endtask

    // Reset, push a (held), push b, then check the ramp from the cycle after b is taken.
    task automatic seg_test(input string tag, input int a, input int b);
        do_reset();
        push(a);
        chk({tag, "_idle_valid"}, bus.out_valid, 0);
        chk({tag, "_busy_ready"}, bus.in_ready, 0);
        @(negedge clk);
        chk({tag, "_hold"}, $signed(bus.out_data), a);
        chk({tag, "_hold_valid"}, bus.out_valid, 1);
        chk({tag, "_hold_ready"}, bus.in_ready, 1);
        push(b);
        ramp(tag, 5);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        do_reset();
        for (int c = 0; c < 20; c++) begin
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_data", $signed(bus.out_data), 0);
            chk("rst_ready", bus.in_ready, 1);
            chk("rst_ur", bus.underrun, 0);
            @(negedge clk);
        end

        exp_q = '{100, 100, 110, 120, 130, 140, 140};
        seg_test("up", 100, 140);

        exp_q = '{0, 0, -1, -2, -3, -3, -3};
        seg_test("floor", 0, -3);

        exp_q = '{32767, 32767, 16383, -1, -16385, -32768, -32768};
        seg_test("full", 32767, -32768);

        // Continuous stream 0,40,0,40: gapless triangle, starved only after the last point.
        do_reset();
        idx      = 0;
        rdy_prev = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (bus.in_valid && rdy_prev) idx++;
            if (idx < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'(seq[idx]);
            end else begin
                bus.in_valid = 1'b0;
            end
            rdy_prev = bus.in_ready;
            if (c >= 4) chk("tri_data", $signed(bus.out_data), tri_out[c-4]);
            if (c >= 4 && c < 12) chk("tri_ready", bus.in_ready, tri_rdy[c-4]);
            chk("tri_ur", bus.underrun, (c == 16));
            @(negedge clk);
        end

        // Reset mid-RUN at phase 2 with a point buffered.
        do_reset();
        push(0);
        @(negedge clk);
        push(40);
        @(negedge clk);
        push(8);
        @(negedge clk);
        chk("mid_data", $signed(bus.out_data), 20);
        chk("mid_ready", bus.in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_data", $signed(bus.out_data), 0);
        chk("mrst_ready", bus.in_ready, 1);
        chk("mrst_ur", bus.underrun, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_idle_valid", bus.out_valid, 0);
        chk("mrst_idle_ready", bus.in_ready, 1);
        push(7);
        chk("new_idle_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("new_data", $signed(bus.out_data), 7);
        chk("new_valid", bus.out_valid, 1);
        @(negedge clk);
        chk("new_data2", $signed(bus.out_data), 7);
        chk("new_ur", bus.underrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/linear_interpolator.md
# linear_interpolator

Rate-raising counterpart to the block-summing decimator in the averaging chain. Accepts a slow stream of signed samples through a valid/ready handshake and emits one sample per `clk`, linearly interpolating between consecutive input points over a fixed segment of 2^LOG2_RATIO cycles. Sits between a decimated processing path (e.g. averaged error signal) and the full-rate consumer (DAC/PID setpoint), so a slowly updated value drives the fast side without steps.

## Interface
- `DATA_BITS`, 16: width of input/output samples, two's complement.
- `LOG2_RATIO`, 8: segment length is 2^LOG2_RATIO output cycles; legal range 1..16.
- `clk` in 1: output-rate clock.
- `reset` in 1: synchronous, active-high.
- `in_data` in DATA_BITS: signed input point.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: block can accept a point this cycle.
- `out_data` out DATA_BITS: signed interpolated sample.
- `out_valid` out 1: `out_data` meaningful (a point has been received).
- `underrun` out 1: one-cycle pulse when a segment ends with no next point buffered.

## Operation
- Registers: `p_tgt` (segment end point), `nxt`/`nxt_valid` (one-entry input buffer), `step` (DATA_BITS+1 signed), `acc` (DATA_BITS+LOG2_RATIO+1 signed), `phase` (LOG2_RATIO bits), `state`.
- `in_ready = ~nxt_valid` (register-driven, no combinational path from `in_valid`). Accept = `in_valid & in_ready`; accepted point written to `nxt`, `nxt_valid` set.
- `out_data = acc >>> LOG2_RATIO` (arithmetic, floor), low DATA_BITS bits. `out_valid = (state != IDLE)`.
- IDLE: `acc = 0`. If `nxt_valid`: `acc <= nxt<<<LOG2_RATIO`, `p_tgt <= nxt`, clear `nxt_valid`, -> HOLD.
- HOLD: output constant `p_tgt`. If `nxt_valid`: `step <= nxt - p_tgt`, `p_tgt <= nxt`, `phase <= 0`, clear `nxt_valid`, -> RUN.
- RUN: each cycle `acc <= acc + step`, `phase <= phase + 1`. On `phase == 2^LOG2_RATIO-1`: `acc` reaches exactly `p_tgt<<<LOG2_RATIO`; if `nxt_valid` load next segment in the same edge (`step <= nxt - p_tgt`, `p_tgt <= nxt`, `phase <= 0`, clear `nxt_valid`, stay RUN, no gap); else -> HOLD and pulse `underrun`.
- Sample k of a segment from A to B: `A + floor(k*(B-A)/2^LOG2_RATIO)`, k = 0..2^LOG2_RATIO-1; endpoints exact, no accumulated drift.
- Step width DATA_BITS+1 so full-scale swings (max to min) never overflow.
- Reset at any time: all registers 0, state IDLE, `in_ready=1`, `out_valid=0`, `out_data=0`, `underrun=0`; in-flight segment and buffered point discarded.

## Timing
- Accept at edge t -> `nxt_valid` high in cycle t+1 -> state change at edge t+1.
- First point: `out_data` equals it from cycle t+2 (IDLE->HOLD), `out_valid` rises the same cycle.
- Second point accepted while HOLD: RUN starts cycle t+2, first ramp sample (k=0) equals old point, k=1 in t+3.
- Segment = exactly 2^LOG2_RATIO cycles; back-to-back points produce a continuous ramp.
- `in_ready` low from accept+1 until the cycle after the buffer is consumed; at most one point per segment sustained.
- `underrun` asserted in the first HOLD cycle after a starved segment.

## Structure
- Shared package/header `averaging_pkg`: state encoding localparams (IDLE=0, HOLD=1, RUN=2) and a width helper for `acc`.
- One natural sub-module: `interp_skid`, one-entry valid/ready buffer providing `nxt`, `nxt_valid`, consume strobe. Remainder (FSM, step/acc datapath) in the top.

## Test plan
- Reset, no input -> `out_valid=0`, `out_data=0`, `in_ready=1`, `underrun=0` for 20 cycles.
- LOG2_RATIO=2: push 100, then 140 -> out 100 (hold), then ramp 100,110,120,130, then 140 constant; `underrun` one pulse at entry to hold.
- LOG2_RATIO=2: push 0, then -3 -> ramp 0,-1,-2,-3 (floor rounding), then -3 held.
- DATA_BITS=16, LOG2_RATIO=2: push 32767 then -32768 -> ramp 32767,16383,-1,-16385, then -32768; no wrap.
- Continuous `in_valid` with sequence 0,40,0,40 (ratio 4) -> gapless triangle 0,10,20,30,40,30,20,10,0,...; `in_ready` low except one cycle per segment; no `underrun` until stream stops.
- Assert `reset` mid-RUN (phase 2) with a point buffered -> next cycle IDLE, all outputs 0; after new point 7, output 7 with no residue from old segment.
